// File: rtl/xilinx_phy10g_pkg.sv
// Shared types and defaults for the 10G PHY QPLL bring-up controller.
package xilinx_phy10g_pkg;

  typedef enum logic [2:0] {
    StOff,
    StReset,
    StWaitLock,
    StStable,
    StReady,
    StFail
  } qpll_state_t;

  localparam int unsigned DefResetCycles = 16;
  localparam int unsigned DefLockTimeout = 65536;
  localparam int unsigned DefLockStable  = 256;
  localparam int unsigned DefMaxRetries  = 3;

  // Counter width able to hold 0..limit-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/xilinx_phy10g_qpll_ctrl_quad.sv
// Single-quad QPLL supervisor: input synchronisers, bring-up FSM, retry and timeout counters.
module xilinx_phy10g_qpll_ctrl_quad
  import xilinx_phy10g_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = DefResetCycles,
  parameter int unsigned LOCK_TIMEOUT = DefLockTimeout,
  parameter int unsigned LOCK_STABLE  = DefLockStable,
  parameter int unsigned MAX_RETRIES  = DefMaxRetries,
  parameter int unsigned RETRY_W      = cnt_width(MAX_RETRIES + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               enable_i,
  input  logic               qplllock_i,
  input  logic               refclklost_i,
  output logic               qpllpd_o,
  output logic               qpllreset_o,
  output logic               ready_o,
  output logic               fail_o,
  output logic               lock_lost_o,
  output logic [RETRY_W-1:0] retry_cnt_o
);

  localparam int unsigned RstW = cnt_width(RESET_CYCLES);
  localparam int unsigned TmoW = cnt_width(LOCK_TIMEOUT);
  localparam int unsigned StbW = cnt_width(LOCK_STABLE);

  localparam logic [RstW-1:0]    RstMax   = RstW'(RESET_CYCLES - 1);
  localparam logic [TmoW-1:0]    TmoMax   = TmoW'(LOCK_TIMEOUT - 1);
  localparam logic [StbW-1:0]    StbMax   = StbW'(LOCK_STABLE - 1);
  localparam logic [RETRY_W-1:0] RetryMax = RETRY_W'(MAX_RETRIES);

  qpll_state_t state_q, state_d;
  logic [RstW-1:0]    rst_cnt_q, rst_cnt_d;
  logic [TmoW-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic [StbW-1:0]    stb_cnt_q, stb_cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;

  logic lock_meta_q, lock_s_q, lost_meta_q, lost_s_q, en_q;
  logic qpllpd_q, qpllreset_q, ready_q, fail_q, lock_lost_q;

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    stb_cnt_d = stb_cnt_q;
    retry_d   = retry_q;

    unique case (state_q)
      StOff: begin
        rst_cnt_d = '0;
        tmo_cnt_d = '0;
        stb_cnt_d = '0;
        retry_d   = '0;
        if (en_q) state_d = StReset;
      end
      StReset: begin
        stb_cnt_d = '0;
        if (rst_cnt_q == RstMax) begin
          rst_cnt_d = '0;
          tmo_cnt_d = '0;
          state_d   = StWaitLock;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      StWaitLock, StStable: begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        // Timeout or refclk loss takes precedence over any lock progress.
        if ((tmo_cnt_q == TmoMax) || lost_s_q) begin
          stb_cnt_d = '0;
          rst_cnt_d = '0;
          if (retry_q == RetryMax) begin
            state_d = StFail;
          end else begin
            retry_d = retry_q + 1'b1;
            state_d = StReset;
          end
        end else if (state_q == StWaitLock) begin
          if (lock_s_q) state_d = StStable;
        end else if (!lock_s_q) begin
          stb_cnt_d = '0;
          state_d   = StWaitLock;
        end else if (stb_cnt_q == StbMax) begin
          state_d = StReady;
        end else begin
          stb_cnt_d = stb_cnt_q + 1'b1;
        end
      end
      StReady: begin
        if (!lock_s_q || lost_s_q) begin
          retry_d   = '0;
          rst_cnt_d = '0;
          stb_cnt_d = '0;
          state_d   = StReset;
        end
      end
      StFail: state_d = StFail;
      default: state_d = StOff;
    endcase

    if (!en_q) begin
      state_d   = StOff;
      rst_cnt_d = '0;
      tmo_cnt_d = '0;
      stb_cnt_d = '0;
      retry_d   = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      lost_meta_q <= 1'b0;
      lost_s_q    <= 1'b0;
      en_q        <= 1'b0;
      state_q     <= StOff;
      rst_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      stb_cnt_q   <= '0;
      retry_q     <= '0;
      qpllpd_q    <= 1'b1;
      qpllreset_q <= 1'b1;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      lock_meta_q <= qplllock_i;
      lock_s_q    <= lock_meta_q;
      lost_meta_q <= refclklost_i;
      lost_s_q    <= lost_meta_q;
      en_q        <= enable_i;
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      stb_cnt_q   <= stb_cnt_d;
      retry_q     <= retry_d;
      // Outputs decode the state being entered so they change on that same edge.
      qpllpd_q    <= (state_d == StOff) || (state_d == StFail);
      qpllreset_q <= (state_d == StOff) || (state_d == StFail) || (state_d == StReset);
      ready_q     <= (state_d == StReady);
      fail_q      <= (state_d == StFail);
      lock_lost_q <= (state_q == StReady) && (state_d == StReset);
    end
  end

  assign qpllpd_o    = qpllpd_q;
  assign qpllreset_o = qpllreset_q;
  assign ready_o     = ready_q;
  assign fail_o      = fail_q;
  assign lock_lost_o = lock_lost_q;
  assign retry_cnt_o = retry_q;

endmodule

// File: rtl/xilinx_phy10g_qpll_ctrl.sv
// QPLL bring-up and supervision for NUM_QUADS independent GTXE2_COMMON quads.
module xilinx_phy10g_qpll_ctrl
  import xilinx_phy10g_pkg::*;
#(
  parameter int unsigned NUM_QUADS    = 1,
  parameter int unsigned RESET_CYCLES = DefResetCycles,
  parameter int unsigned LOCK_TIMEOUT = DefLockTimeout,
  parameter int unsigned LOCK_STABLE  = DefLockStable,
  parameter int unsigned MAX_RETRIES  = DefMaxRetries
) (
  input  logic                                              clk_i,
  input  logic                                              rst_i,
  input  logic [NUM_QUADS-1:0]                              enable_i,
  input  logic [NUM_QUADS-1:0]                              qplllock_i,
  input  logic [NUM_QUADS-1:0]                              refclklost_i,
  output logic [NUM_QUADS-1:0]                              qpllpd_o,
  output logic [NUM_QUADS-1:0]                              qpllreset_o,
  output logic [NUM_QUADS-1:0]                              ready_o,
  output logic [NUM_QUADS-1:0]                              fail_o,
  output logic [NUM_QUADS-1:0]                              lock_lost_o,
  output logic [NUM_QUADS*cnt_width(MAX_RETRIES + 1)-1:0]   retry_cnt_o
);

  localparam int unsigned RetryW = cnt_width(MAX_RETRIES + 1);

  for (genvar q = 0; q < NUM_QUADS; q++) begin : g_quad
    xilinx_phy10g_qpll_ctrl_quad #(
      .RESET_CYCLES (RESET_CYCLES),
      .LOCK_TIMEOUT (LOCK_TIMEOUT),
      .LOCK_STABLE  (LOCK_STABLE),
      .MAX_RETRIES  (MAX_RETRIES),
      .RETRY_W      (RetryW)
    ) u_quad (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .enable_i     (enable_i[q]),
      .qplllock_i   (qplllock_i[q]),
      .refclklost_i (refclklost_i[q]),
      .qpllpd_o     (qpllpd_o[q]),
      .qpllreset_o  (qpllreset_o[q]),
      .ready_o      (ready_o[q]),
      .fail_o       (fail_o[q]),
      .lock_lost_o  (lock_lost_o[q]),
      .retry_cnt_o  (retry_cnt_o[q*RetryW +: RetryW])
    );
  end

endmodule

// File: tb/tb_xilinx_phy10g_qpll_ctrl.sv
// Directed bench for the QPLL controller: vector table for the nominal/lock-loss flow plus corner sequences.
module tb_xilinx_phy10g_qpll_ctrl;

  localparam int NQ = 2;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic [NQ-1:0] enable_i = '0;
  logic [NQ-1:0] qplllock_i = '0;
  logic [NQ-1:0] refclklost_i = '0;
  logic [NQ-1:0] qpllpd_o, qpllreset_o, ready_o, fail_o, lock_lost_o;
  logic [3:0]    retry_cnt_o;
  logic [13:0]   obs;

  int tests = 0;
  int fails = 0;
  int cyc = -1;

  xilinx_phy10g_qpll_ctrl #(
    .NUM_QUADS    (NQ),
    .RESET_CYCLES (4),
    .LOCK_TIMEOUT (32),
    .LOCK_STABLE  (8),
    .MAX_RETRIES  (2)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .enable_i     (enable_i),
    .qplllock_i   (qplllock_i),
    .refclklost_i (refclklost_i),
    .qpllpd_o     (qpllpd_o),
    .qpllreset_o  (qpllreset_o),
    .ready_o      (ready_o),
    .fail_o       (fail_o),
    .lock_lost_o  (lock_lost_o),
    .retry_cnt_o  (retry_cnt_o)
  );

  always #5 clk = ~clk;

  // {pd, reset, ready, fail, lock_lost, retry_cnt}
  assign obs = {qpllpd_o, qpllreset_o, ready_o, fail_o, lock_lost_o, retry_cnt_o};

  typedef struct {
    int         e;
    logic [1:0] en;
    logic [1:0] lock;
    logic [1:0] lost;
    logic [13:0] exp;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int e);
    while (cyc < e) tick();
  endtask

  // Inputs set here are sampled at edge e; outputs are then checked after edge e.
  task automatic drive_at(input int e, input logic [1:0] en, input logic [1:0] lock,
                          input logic [1:0] lost);
    run_to(e - 1);
    enable_i     = en;
    qplllock_i   = lock;
    refclklost_i = lost;
    run_to(e);
  endtask

  task automatic do_reset();
    enable_i     = '0;
    qplllock_i   = '0;
    refclklost_i = '0;
    rst_i        = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    cyc   = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{e: 0,  en: 2'b01, lock: 2'b00, lost: 2'b00, exp: {2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 4'h0}};
    vecs[1]  = '{e: 1,  en: 2'b01, lock: 2'b00, lost: 2'b00, exp: {2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 4'h0}};
    vecs[2]  = '{e: 4,  en: 2'b01, lock: 2'b00, lost: 2'b00, exp: {2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 4'h0}};
    vecs[3]  = '{e: 5,  en: 2'b01, lock: 2'b00, lost: 2'b00, exp: {2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 4'h0}};
    vecs[4]  = '{e: 10, en: 2'b01, lock: 2'b01, lost: 2'b00, exp: {2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 4'h0}};
    vecs[5]  = '{e: 19, en: 2'b01, lock: 2'b01, lost: 2'b00, exp: {2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 4'h0}};
    vecs[6]  = '{e: 20, en: 2'b01, lock: 2'b01, lost: 2'b00, exp: {2'b10, 2'b10, 2'b01, 2'b00, 2'b00, 4'h0}};
    vecs[7]  = '{e: 25, en: 2'b01, lock: 2'b00, lost: 2'b00, exp: {2'b10, 2'b10, 2'b01, 2'b00, 2'b00, 4'h0}};
    vecs[8]  = '{e: 26, en: 2'b01, lock: 2'b00, lost: 2'b00, exp: {2'b10, 2'b10, 2'b01, 2'b00, 2'b00, 4'h0}};
    vecs[9]  = '{e: 27, en: 2'b01, lock: 2'b00, lost: 2'b00, exp: {2'b10, 2'b11, 2'b00, 2'b00, 2'b01, 4'h0}};
    vecs[10] = '{e: 28, en: 2'b01, lock: 2'b00, lost: 2'b00, exp: {2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 4'h0}};
    vecs[11] = '{e: 30, en: 2'b01, lock: 2'b00, lost: 2'b00, exp: {2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 4'h0}};
    vecs[12] = '{e: 31, en: 2'b01, lock: 2'b00, lost: 2'b00, exp: {2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 4'h0}};
    vecs[13] = '{e: 33, en: 2'b01, lock: 2'b00, lost: 2'b00, exp: {2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 4'h0}};

    // Reset state
    do_reset();
    cmp("reset_vals", 32'(obs), 32'({2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 4'h0}));

    // Nominal bring-up then lock loss in READY
    for (int i = 0; i < NV; i++) begin
      drive_at(vecs[i].e, vecs[i].en, vecs[i].lock, vecs[i].lost);
      cmp($sformatf("vec%0d_edge%0d", i, vecs[i].e), 32'(obs), 32'(vecs[i].exp));
    end

    // Timeout, retries, FAIL, then enable drop and clean restart
    do_reset();
    drive_at(0, 2'b01, 2'b00, 2'b00);
    run_to(36);
    cmp("tmo_rc_e36", 32'(retry_cnt_o), 32'h0);
    run_to(37);
    cmp("tmo_rc_e37", 32'(retry_cnt_o), 32'h1);
    cmp("tmo_rst_e37", 32'(qpllreset_o), 32'h3);
    run_to(72);
    cmp("tmo_rc_e72", 32'(retry_cnt_o), 32'h1);
    run_to(73);
    cmp("tmo_rc_e73", 32'(retry_cnt_o), 32'h2);
    run_to(108);
    cmp("tmo_fail_e108", 32'({fail_o, qpllpd_o}), 32'({2'b00, 2'b10}));
    run_to(109);
    cmp("tmo_fail_e109", 32'({fail_o, qpllpd_o, qpllreset_o}), 32'({2'b01, 2'b11, 2'b11}));
    run_to(120);
    cmp("fail_hold_e120", 32'(fail_o), 32'h1);
    drive_at(121, 2'b00, 2'b00, 2'b00);
    run_to(122);
    cmp("fail_disable", 32'(obs), 32'({2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 4'h0}));
    drive_at(125, 2'b01, 2'b00, 2'b00);
    run_to(126);
    cmp("reenable_pd", 32'({qpllpd_o, qpllreset_o, retry_cnt_o}), 32'({2'b10, 2'b11, 4'h0}));

    // Lock glitch during STABLE
    do_reset();
    drive_at(0, 2'b01, 2'b00, 2'b00);
    drive_at(10, 2'b01, 2'b01, 2'b00);
    drive_at(15, 2'b01, 2'b00, 2'b00);
    drive_at(16, 2'b01, 2'b01, 2'b00);
    run_to(20);
    cmp("glitch_noready_e20", 32'(ready_o), 32'h0);
    run_to(25);
    cmp("glitch_noready_e25", 32'(ready_o), 32'h0);
    run_to(26);
    cmp("glitch_ready_e26", 32'({ready_o, retry_cnt_o}), 32'({2'b01, 4'h0}));

    // refclklost pulse in WAIT_LOCK, then coincident timeout and lock
    do_reset();
    drive_at(0, 2'b01, 2'b00, 2'b00);
    drive_at(10, 2'b01, 2'b00, 2'b01);
    drive_at(11, 2'b01, 2'b00, 2'b00);
    cmp("lost_rc_e11", 32'(retry_cnt_o), 32'h0);
    run_to(12);
    cmp("lost_rc_e12", 32'({qpllreset_o, retry_cnt_o}), 32'({2'b11, 4'h1}));
    run_to(15);
    cmp("lost_rst_e15", 32'(qpllreset_o), 32'h3);
    run_to(16);
    cmp("lost_rst_e16", 32'(qpllreset_o), 32'h2);
    drive_at(46, 2'b01, 2'b01, 2'b00);
    run_to(47);
    cmp("race_e47", 32'({qpllreset_o, retry_cnt_o}), 32'({2'b10, 4'h1}));
    run_to(48);
    cmp("race_e48", 32'({qpllreset_o, ready_o, retry_cnt_o}), 32'({2'b11, 2'b00, 4'h2}));
    run_to(60);
    cmp("race_noready_e60", 32'(ready_o), 32'h0);
    run_to(61);
    cmp("race_ready_e61", 32'(ready_o), 32'h1);

    // Asynchronous reset mid-STABLE
    do_reset();
    drive_at(0, 2'b01, 2'b00, 2'b00);
    drive_at(10, 2'b01, 2'b01, 2'b00);
    run_to(15);
    rst_i = 1'b1;
    #2;
    cmp("async_rst", 32'(obs), 32'({2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 4'h0}));
    do_reset();
    drive_at(0, 2'b01, 2'b01, 2'b00);
    run_to(1);
    cmp("restart_e1", 32'({qpllpd_o, qpllreset_o}), 32'({2'b10, 2'b11}));
    run_to(5);
    cmp("restart_e5", 32'(qpllreset_o), 32'h2);
    run_to(14);
    cmp("restart_ready_e14", 32'(ready_o), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
